// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the EX-stage issue logic and mul_div_unit.
interface mul_div_unit_if #(parameter int XLEN = 32);
    logic            START;
    logic [2:0]      FUNCT3;
    logic [XLEN-1:0] OPERAND_A;
    logic [XLEN-1:0] OPERAND_B;
    logic            FLUSH;
    logic            BUSY;
    logic            DONE;
    logic [XLEN-1:0] RESULT;

    modport master (
        output START, FUNCT3, OPERAND_A, OPERAND_B, FLUSH,
        input  BUSY, DONE, RESULT
    );

    modport slave (
        input  START, FUNCT3, OPERAND_A, OPERAND_B, FLUSH,
        output BUSY, DONE, RESULT
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit with START/BUSY/DONE handshake.
// Optional FAST_MUL_EN: single-cycle 33x33 signed multiplier for the MUL family.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input logic           CLK,
    input logic           RESET,
    mul_div_unit_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for START; special cases resolved here
    // CALC  | 32 shift-add / restoring-divide iterations
    // FIN   | sign fix-up, load RESULT, pulse DONE
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t            state, state_next;
    logic              accept;
    logic [2:0]        op;
    logic              neg;
    logic [4:0]        cnt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mcand, quot, rem, divisor;
    logic              busy_q, done_q;
    logic [XLEN-1:0]   result_q;

    logic              a_sign, b_sign, abs_a, abs_b, neg_in;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, special, fast;
    logic [XLEN:0]     mul_sum, part_rem;
    logic              fits;
    logic [2*XLEN-1:0] mul_full;
    logic [XLEN-1:0]   fin_result;

    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    always_comb begin
        a_sign = bus.OPERAND_A[XLEN-1];
        b_sign = bus.OPERAND_B[XLEN-1];
        abs_a  = 1'b0;
        abs_b  = 1'b0;
        neg_in = 1'b0;
        unique case (bus.FUNCT3)
            3'b001, 3'b100: begin
                abs_a  = a_sign;
                abs_b  = b_sign;
                neg_in = a_sign ^ b_sign;
            end
            3'b010: begin
                abs_a  = a_sign;
                neg_in = a_sign;
            end
            3'b110: begin
                abs_a  = a_sign;
                abs_b  = b_sign;
                neg_in = a_sign;
            end
            default: ;
        endcase
        mag_a    = abs_a ? -bus.OPERAND_A : bus.OPERAND_A;
        mag_b    = abs_b ? -bus.OPERAND_B : bus.OPERAND_B;
        div_zero = bus.FUNCT3[2] && (bus.OPERAND_B == '0);
        // only DIV (100) and REM (110) are signed, both have funct3[0]=0
        div_ovf  = bus.FUNCT3[2] && !bus.FUNCT3[0] &&
                   (bus.OPERAND_A == MIN_INT) && (bus.OPERAND_B == '1);
        special  = div_zero || div_ovf;
    end

`ifdef FAST_MUL_EN
    logic signed [XLEN:0]     fast_a, fast_b;
    logic signed [2*XLEN+1:0] fast_full;
    logic [2*XLEN-1:0]        fast_prod;

    always_comb begin
        fast_a    = {((bus.FUNCT3 == 3'b001) || (bus.FUNCT3 == 3'b010)) && a_sign, bus.OPERAND_A};
        fast_b    = {(bus.FUNCT3 == 3'b001) && b_sign, bus.OPERAND_B};
        fast_full = fast_a * fast_b;
        fast_prod = fast_full[2*XLEN-1:0];
    end
    assign fast = ~bus.FUNCT3[2];
`else
    assign fast = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        if (bus.FLUSH) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: if (bus.START) begin
                    accept     = 1'b1;
                    state_next = (special || fast) ? FIN : CALC;
                end
                CALC:    if (&cnt) state_next = FIN;
                FIN:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
        part_rem = {rem, quot[XLEN-1]};
        fits     = part_rem >= {1'b0, divisor};
        mul_full = neg ? -prod : prod;
        unique case (op)
            3'b000:                 fin_result = mul_full[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fin_result = mul_full[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fin_result = neg ? -quot : quot;
            default:                fin_result = neg ? -rem : rem;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            op       <= '0;
            neg      <= 1'b0;
            cnt      <= '0;
            prod     <= '0;
            mcand    <= '0;
            quot     <= '0;
            rem      <= '0;
            divisor  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            busy_q <= (state_next != IDLE);
            done_q <= 1'b0;
            if (accept) begin
                op  <= bus.FUNCT3;
                cnt <= '0;
                if (special) begin
                    // park the answer where FIN reads it, with no sign fix-up
                    neg  <= 1'b0;
                    quot <= div_zero ? '1 : MIN_INT;
                    rem  <= div_zero ? bus.OPERAND_A : '0;
`ifdef FAST_MUL_EN
                end else if (fast) begin
                    neg  <= 1'b0;
                    prod <= fast_prod;
`endif
                end else begin
                    neg     <= neg_in;
                    prod    <= {{XLEN{1'b0}}, mag_b};
                    mcand   <= mag_a;
                    quot    <= mag_a;
                    rem     <= '0;
                    divisor <= mag_b;
                end
            end else if (state == CALC && !bus.FLUSH) begin
                cnt <= cnt + 5'd1;
                if (op[2]) begin
                    rem  <= fits ? XLEN'(part_rem - {1'b0, divisor}) : part_rem[XLEN-1:0];
                    quot <= {quot[XLEN-2:0], fits};
                end else begin
                    prod <= {mul_sum, prod[XLEN-1:1]};
                end
            end else if (state == FIN && !bus.FLUSH) begin
                result_q <= fin_result;
                done_q   <= 1'b1;
            end
        end
    end

    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
    assign bus.RESULT = result_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: vector table plus flush/reset/back-to-back sequences.
module tb_mul_div_unit;
    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   errors = 0;

    mul_div_unit_if bus ();
    mul_div_unit dut (.CLK(CLK), .RESET(RESET), .bus(bus));

    always #5 CLK = ~CLK;

`ifdef FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // called #1 after a posedge; START is sampled on the next edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.START     = 1'b1;
        bus.FUNCT3    = op;
        bus.OPERAND_A = a;
        bus.OPERAND_B = b;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic [31:0] res, output logic busy_ok);
        lat     = -1;
        busy_ok = bus.BUSY;
        res     = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(posedge CLK);
            #1;
            if (bus.DONE) begin
                lat = c;
                res = bus.RESULT;
                if (bus.BUSY) busy_ok = 1'b0;
                break;
            end
            if (!bus.BUSY) busy_ok = 1'b0;
        end
    endtask

    task automatic count_done(input int n, output int seen);
        seen = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge CLK);
            #1;
            if (bus.DONE) seen++;
        end
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [31:0] res;
        logic        busy_ok;
        logic [31:0] prev;

        vecs[0]  = '{"mul",         3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
        vecs[1]  = '{"mulh",        3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT};
        vecs[2]  = '{"mulhu",       3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT};
        vecs[3]  = '{"mulhsu",      3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT};
        vecs[4]  = '{"mulhu_max",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
        vecs[5]  = '{"mulh_m1m1",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT};
        vecs[6]  = '{"mul_big",     3'b000, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, MUL_LAT};
        vecs[7]  = '{"divu",        3'b101, 32'd100,       32'd7,         32'd14,         33};
        vecs[8]  = '{"remu",        3'b111, 32'd100,       32'd7,         32'd2,          33};
        vecs[9]  = '{"rem_neg",     3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        vecs[10] = '{"div_neg",     3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        vecs[11] = '{"divu_max",    3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
        vecs[12] = '{"div_by0",     3'b100, 32'h0000_002A, 32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{"rem_by0",     3'b110, 32'h0000_002A, 32'd0,         32'h0000_002A, 1};
        vecs[14] = '{"divu_by0",    3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[15] = '{"remu_by0",    3'b111, 32'd5,         32'd0,         32'd5,          1};
        vecs[16] = '{"div_ovf",     3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[17] = '{"rem_ovf",     3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[18] = '{"div_negneg",  3'b100, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,         33};
        vecs[19] = '{"rem_posneg",  3'b110, 32'd100,       32'hFFFF_FFF9, 32'd2,          33};

        RESET         = 1'b0;
        bus.START     = 1'b0;
        bus.FLUSH     = 1'b0;
        bus.FUNCT3    = '0;
        bus.OPERAND_A = '0;
        bus.OPERAND_B = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", {31'd0, bus.BUSY}, 32'd0);
        check("rst_done", {31'd0, bus.DONE}, 32'd0);
        check("rst_result", bus.RESULT, 32'd0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 20; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat, res, busy_ok);
            check({vecs[i].name, "_result"}, res, vecs[i].exp);
            check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
            check({vecs[i].name, "_busy"}, {31'd0, busy_ok}, 32'd1);
            @(posedge CLK);
            #1;
            check({vecs[i].name, "_pulse"}, {31'd0, bus.DONE}, 32'd0);
        end

        // flush 10 cycles into a DIV
        prev = bus.RESULT;
        issue(3'b100, 32'd1000, 32'd3);
        repeat (9) @(posedge CLK);
        #1;
        bus.FLUSH = 1'b1;
        @(posedge CLK);
        #1;
        bus.FLUSH = 1'b0;
        check("flush_busy", {31'd0, bus.BUSY}, 32'd0);
        count_done(40, seen);
        check("flush_no_done", seen, 0);
        check("flush_result_kept", bus.RESULT, prev);

        // START while busy is ignored
        issue(3'b101, 32'd100, 32'd7);
        repeat (4) @(posedge CLK);
        #1;
        issue(3'b000, 32'd3, 32'd3);
        wait_done(lat, res, busy_ok);
        check("ignore_result", res, 32'd14);
        check("ignore_latency", lat, 33 - 5);
        count_done(40, seen);
        check("ignore_no_extra_done", seen, 0);

        // START and FLUSH together
        prev = bus.RESULT;
        bus.FLUSH = 1'b1;
        issue(3'b100, 32'd50, 32'd5);
        bus.FLUSH = 1'b0;
        check("startflush_busy", {31'd0, bus.BUSY}, 32'd0);
        count_done(40, seen);
        check("startflush_no_done", seen, 0);
        check("startflush_result", bus.RESULT, prev);

        // asynchronous reset mid-DIV
        issue(3'b100, 32'd1000, 32'd7);
        repeat (10) @(posedge CLK);
        #3;
        RESET = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, bus.BUSY}, 32'd0);
        check("async_rst_done", {31'd0, bus.DONE}, 32'd0);
        check("async_rst_result", bus.RESULT, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        issue(3'b101, 32'd9, 32'd3);
        wait_done(lat, res, busy_ok);
        check("post_rst_result", res, 32'd3);
        check("post_rst_latency", lat, 33);

        // back-to-back issue on the DONE cycle
        @(posedge CLK);
        #1;
        issue(3'b101, 32'd100, 32'd7);
        wait_done(lat, res, busy_ok);
        check("b2b_first_result", res, 32'd14);
        issue(3'b111, 32'd100, 32'd9);
        check("b2b_pulse_clean", {31'd0, bus.DONE}, 32'd0);
        check("b2b_accepted_busy", {31'd0, bus.BUSY}, 32'd1);
        wait_done(lat, res, busy_ok);
        check("b2b_second_result", res, 32'd1);
        check("b2b_second_latency", lat, 33);
        check("b2b_second_busy", {31'd0, busy_ok}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the register file. It consumes the two register-file read operands (DATA_OUT1/DATA_OUT2 forwarded through ID/EX) and produces a 32-bit result for the EX/MEM pipeline. It runs a START/BUSY/DONE handshake so the hazard unit can stall the pipeline while it computes.

## Interface
- XLEN, 32: operand/result width; only 32 is supported.
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- START  in  1  one-cycle request; operands and FUNCT3 are sampled on the edge where START=1 and the unit is idle.
- FUNCT3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OPERAND_A  in  32  rs1 value (dividend / multiplicand).
- OPERAND_B  in  32  rs2 value (divisor / multiplier).
- FLUSH  in  1  aborts any operation in flight.
- BUSY  out  1  high while an accepted op is computing.
- DONE  out  1  one-cycle pulse marking RESULT valid.
- RESULT  out  32  result; holds its value until the next DONE.

## Operation
- States:
  - IDLE: accepts START when FLUSH=0, then goes to CALC, or directly to FIN for special cases.
  - CALC: 32 iterations, counter 0..31; leaves for FIN after the iteration with counter=31.
  - FIN: registers RESULT, pulses DONE, returns to IDLE.
- A START that arrives while BUSY=1 is ignored and has no side effects.
- Signed handling:
  - DIV, REM and MULH take the magnitude of both operands; MULHSU takes the magnitude of A only.
  - The core iterates unsigned; the final stage negates the result when the operand signs require it.
  - Remainder sign follows the dividend.
- Multiply: shift-add over a 64-bit product register. MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide: restoring algorithm with a 33-bit partial remainder and a 32-bit quotient register.
- Special cases are resolved in IDLE, go straight to FIN and skip CALC:
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return OPERAND_A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- FLUSH=1 in any state forces IDLE on the next edge. BUSY and DONE drop, RESULT is unchanged and no DONE is emitted.
- If START and FLUSH are both high, FLUSH wins and nothing is accepted.
- RESET asserted (even mid-operation) immediately forces state IDLE, counter 0, BUSY=0, DONE=0, RESULT=0x00000000 and clears internal registers.

## Timing
- The edge that accepts START is N.
- Iterative path: BUSY=1 from after edge N through the cycle before edge N+33. Iterations run on edges N+1..N+32. On edge N+33, RESULT is loaded, DONE=1 for one cycle and BUSY=0.
  - Latency is 33 cycles.
- Special-case path: on edge N+1, RESULT is loaded, DONE=1 and BUSY=0 (1-cycle latency). BUSY is high for exactly one cycle.
- A new START may be accepted on the same edge that ends the DONE cycle (back-to-back issue). DONE of the prior op is still a clean single pulse.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- FAST_MUL_EN defined: MUL, MULH, MULHSU and MULHU use a single-cycle 33x33 signed multiplier. They follow the special-case path (DONE on edge N+1). Divide is unchanged.
- FAST_MUL_EN undefined: all multiplies use the iterative 33-cycle path. No hardware multiplier is inferred.

## Test plan
- MUL: A=7, B=0xFFFFFFFD (-3) → RESULT=0xFFFFFFEB. DONE fires 33 cycles after START (1 cycle with FAST_MUL_EN). BUSY is high throughout.
- MULH and MULHU: A=B=0x80000000 → MULH gives 0x40000000; MULHU gives 0x40000000. MULHSU with A=0xFFFFFFFF, B=2 → 0xFFFFFFFF.
- DIVU 100/7 → 14 and REMU → 2. REM A=0xFFFFFFF9 (-7), B=2 → 0xFFFFFFFF; DIV on the same operands → 0xFFFFFFFD.
- Special cases, each with 1-cycle latency:
  - DIV 0x2A/0 → 0xFFFFFFFF; REM 0x2A/0 → 0x2A.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Abort and ignored requests:
  - FLUSH 10 cycles into a DIV → BUSY drops next cycle, no DONE, RESULT keeps its old value.
  - START during BUSY is ignored: the first op's result is unchanged.
  - START+FLUSH together → nothing is accepted.
- Reset and back-to-back:
  - RESET low mid-DIV → BUSY=0, DONE=0, RESULT=0 immediately, without waiting for CLK.
  - After release, a DIVU 9/3 → 3 completes normally.
  - A back-to-back START on the DONE cycle is accepted.
